// File: rtl/piano_pkg.sv
// rtl/piano_pkg.sv - shared state encoding, note table and key priority helper
package piano_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  localparam int NOTE_W = 12;

  // Half-periods in 1 MHz ticks, C4 up to C5.
  function automatic logic [NOTE_W-1:0] half_ticks(input logic [2:0] idx);
    logic [NOTE_W-1:0] h;
    case (idx)
      3'd0:    h = 12'd1911;
      3'd1:    h = 12'd1703;
      3'd2:    h = 12'd1517;
      3'd3:    h = 12'd1432;
      3'd4:    h = 12'd1276;
      3'd5:    h = 12'd1136;
      3'd6:    h = 12'd1012;
      default: h = 12'd956;
    endcase
    return h;
  endfunction

  function automatic logic [2:0] lowest_set(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) r = 3'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/piano_tone_sched_if.sv
// rtl/piano_tone_sched_if.sv - key/tick inputs and tone outputs of the scheduler
interface piano_tone_sched_if;
  logic       tick;
  logic       en;
  logic [7:0] key;
  logic       tone_out;
  logic [2:0] note_idx;
  logic       note_valid;

  modport master (
    output tick, en, key,
    input  tone_out, note_idx, note_valid
  );

  modport slave (
    input  tick, en, key,
    output tone_out, note_idx, note_valid
  );
endinterface

// File: rtl/piano_tone_sched_key_sync.sv
// rtl/piano_tone_sched_key_sync.sv - two-flop synchronizer for asynchronous levels
module key_sync #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] s1_q, s1_d;
  logic [W-1:0] s2_q, s2_d;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/piano_tone_sched.sv
// rtl/piano_tone_sched.sv - grants one key at a time and plays its square wave
module piano_tone_sched
  import piano_pkg::*;
#(
  parameter int NKEYS     = 8,
  parameter int CNT_W     = 12,
  parameter int GAP_TICKS = 1000
) (
  input  logic              clk,
  input  logic              rst,
  piano_tone_sched_if.slave bus
);

  localparam logic [CNT_W-1:0] GAP_LOAD =
    (GAP_TICKS > 0) ? CNT_W'(GAP_TICKS - 1) : '0;

  logic [NKEYS-1:0] key_s;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tone_q, tone_d;
  logic [2:0]       idx_q, idx_d;
  logic             valid_q, valid_d;
  logic [2:0]       grant_idx;

  key_sync #(.W(NKEYS)) u_key_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.key),
    .q   (key_s)
  );

  function automatic logic [CNT_W-1:0] reload(input logic [2:0] i);
    return CNT_W'(half_ticks(i)) - CNT_W'(1);
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tone_d    = tone_q;
    idx_d     = idx_q;
    valid_d   = valid_q;
    grant_idx = lowest_set(key_s);

    unique case (state_q)
      ST_IDLE: begin
        if (bus.en && (key_s != '0)) begin
          state_d = ST_PLAY;
          idx_d   = grant_idx;
          cnt_d   = reload(grant_idx);
          valid_d = 1'b1;
          tone_d  = 1'b0;
        end
      end

      ST_PLAY: begin
        // Release/disable wins over a same-cycle tick so no toggle leaks out.
        if (!key_s[idx_q] || !bus.en) begin
          tone_d  = 1'b0;
          valid_d = 1'b0;
          if (GAP_TICKS > 0) begin
            state_d = ST_GAP;
            cnt_d   = GAP_LOAD;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end else if (bus.tick) begin
          if (cnt_q == '0) begin
            tone_d = ~tone_q;
            cnt_d  = reload(idx_q);
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end

      ST_GAP: begin
        if (bus.tick) begin
          if (cnt_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      tone_q  <= 1'b0;
      idx_q   <= 3'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tone_q  <= tone_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

  assign bus.tone_out   = tone_q;
  assign bus.note_idx   = idx_q;
  assign bus.note_valid = valid_q;

endmodule

// File: tb/tb_piano_tone_sched.sv
// tb/tb_piano_tone_sched.sv - directed vectors, corner sequences and random model check
module tb_piano_tone_sched;

  localparam int GAP = 1000;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick_r;
  logic       en_r;
  logic [7:0] key_r;

  int n_cmp = 0;
  int n_err = 0;

  piano_tone_sched_if bus ();
  piano_tone_sched_if bus0 ();

  assign bus.tick  = tick_r;
  assign bus.en    = en_r;
  assign bus.key   = key_r;
  assign bus0.tick = tick_r;
  assign bus0.en   = en_r;
  assign bus0.key  = key_r;

  piano_tone_sched #(.NKEYS(8), .CNT_W(12), .GAP_TICKS(GAP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  piano_tone_sched #(.NKEYS(8), .CNT_W(12), .GAP_TICKS(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] key;
    logic [2:0] idx;
    int         half;
  } vec_t;

  vec_t vecs[8];
  int   half_tab[8];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tone(input logic want, input int bound, output int n);
    n = 0;
    while (bus.tone_out !== want && n < bound) begin
      cyc();
      n++;
    end
  endtask

  task automatic wait_valid(input logic want, input int bound, output int n);
    n = 0;
    while (bus.note_valid !== want && n < bound) begin
      cyc();
      n++;
    end
  endtask

  // Reference model: notes measured in elapsed ticks, not a down-counter.
  int         m_mode;
  int         m_idx;
  int         m_ticks;
  int         m_gap;
  logic [7:0] m_s1;
  logic [7:0] m_ks;

  task automatic model_step();
    case (m_mode)
      0: begin
        if (en_r && m_ks != 8'd0) begin
          for (int i = 7; i >= 0; i--) if (m_ks[i]) m_idx = i;
          m_ticks = 0;
          m_mode  = 1;
        end
      end
      1: begin
        if (!m_ks[m_idx] || !en_r) begin
          m_mode = 2;
          m_gap  = 0;
        end else if (tick_r) begin
          m_ticks++;
        end
      end
      default: begin
        if (tick_r) begin
          m_gap++;
          if (m_gap == GAP) m_mode = 0;
        end
      end
    endcase
    m_ks = m_s1;
    m_s1 = key_r;
  endtask

  initial begin
    int n;
    int exp_w;
    int act_w;

    vecs[0] = '{8'h20, 3'd5, 1136};
    vecs[1] = '{8'h84, 3'd2, 1517};
    vecs[2] = '{8'h01, 3'd0, 1911};
    vecs[3] = '{8'h80, 3'd7, 956};
    vecs[4] = '{8'h0a, 3'd1, 1703};
    vecs[5] = '{8'h18, 3'd3, 1432};
    vecs[6] = '{8'h70, 3'd4, 1276};
    vecs[7] = '{8'hc0, 3'd6, 1012};
    half_tab = '{1911, 1703, 1517, 1432, 1276, 1136, 1012, 956};

    rst    = 1'b1;
    tick_r = 1'b0;
    en_r   = 1'b0;
    key_r  = 8'h00;
    #1;
    check("reset_tone", bus.tone_out, 0);
    check("reset_valid", bus.note_valid, 0);
    check("reset_idx", bus.note_idx, 0);
    #20;
    @(posedge clk);
    #1;
    rst    = 1'b0;
    en_r   = 1'b1;
    tick_r = 1'b1;

    for (int v = 0; v < 8; v++) begin
      key_r = vecs[v].key;
      cyc(); cyc();
      check($sformatf("v%0d_pre_grant_valid", v), bus.note_valid, 0);
      cyc();
      check($sformatf("v%0d_grant_valid", v), bus.note_valid, 1);
      check($sformatf("v%0d_grant_idx", v), bus.note_idx, vecs[v].idx);
      check($sformatf("v%0d_start_tone", v), bus.tone_out, 0);
      wait_tone(1'b1, 4000, n);
      check($sformatf("v%0d_half_hi", v), n, vecs[v].half);
      wait_tone(1'b0, 4000, n);
      check($sformatf("v%0d_half_lo", v), n, vecs[v].half);
      key_r = 8'h00;
      cyc(); cyc();
      check($sformatf("v%0d_release_lag", v), bus.note_valid, 1);
      cyc();
      check($sformatf("v%0d_release_valid", v), bus.note_valid, 0);
      check($sformatf("v%0d_release_tone", v), bus.tone_out, 0);
      repeat (GAP + 1) cyc();
    end

    // No preemption, then the waiting key is granted after exactly the gap.
    key_r = 8'h08;
    cyc(); cyc(); cyc();
    check("nopre_idx", bus.note_idx, 3);
    key_r = 8'h09;
    repeat (50) cyc();
    check("nopre_hold_idx", bus.note_idx, 3);
    check("nopre_hold_valid", bus.note_valid, 1);
    key_r = 8'h01;
    wait_valid(1'b0, 10, n);
    check("nopre_exit_lat", n, 3);
    wait_valid(1'b1, 3000, n);
    check("nopre_gap_len", n, GAP + 1);
    check("nopre_next_idx", bus.note_idx, 0);
    key_r = 8'h00;
    wait_valid(1'b0, 10, n);
    repeat (GAP + 1) cyc();

    // Release lands on the same edge as the terminal-count tick.
    key_r = 8'h10;
    for (int i = 0; i < 1276; i++) cyc();
    check("coin_pre_valid", bus.note_valid, 1);
    key_r = 8'h02;
    cyc(); cyc();
    check("coin_pre_tone", bus.tone_out, 0);
    check("coin_pre_valid2", bus.note_valid, 1);
    cyc();
    check("coin_exit_valid", bus.note_valid, 0);
    check("coin_exit_tone", bus.tone_out, 0);
    wait_valid(1'b1, 3000, n);
    check("coin_gap_len", n, GAP + 1);
    check("coin_next_idx", bus.note_idx, 1);
    key_r = 8'h00;
    wait_valid(1'b0, 10, n);
    repeat (GAP + 1) cyc();

    // en dropped mid-note, then held key with en=0 must not be granted.
    key_r = 8'h40;
    cyc(); cyc(); cyc();
    check("en_grant_idx", bus.note_idx, 6);
    repeat (20) cyc();
    en_r = 1'b0;
    cyc();
    check("en_exit_valid", bus.note_valid, 0);
    check("en_exit_tone", bus.tone_out, 0);
    check("en_exit_idx_hold", bus.note_idx, 6);
    repeat (GAP + 200) cyc();
    check("en_off_idle_valid", bus.note_valid, 0);
    check("en_off_idle_tone", bus.tone_out, 0);
    en_r = 1'b1;
    cyc();
    check("en_on_grant", bus.note_valid, 1);
    key_r = 8'h00;
    repeat (GAP + 10) cyc();

    // Zero-gap build goes straight back to IDLE on release.
    key_r = 8'h04;
    cyc(); cyc(); cyc();
    check("gap0_grant_idx", bus0.note_idx, 2);
    check("gap0_grant_valid", bus0.note_valid, 1);
    key_r = 8'h02;
    cyc(); cyc(); cyc();
    check("gap0_exit_valid", bus0.note_valid, 0);
    cyc();
    check("gap0_regrant_valid", bus0.note_valid, 1);
    check("gap0_regrant_idx", bus0.note_idx, 1);
    check("gap1000_still_gap", bus.note_valid, 0);
    key_r = 8'h00;
    repeat (GAP + 10) cyc();

    // Asynchronous reset while a note is sounding.
    key_r = 8'h20;
    cyc(); cyc(); cyc();
    wait_tone(1'b1, 2000, n);
    check("rst_pre_tone", bus.tone_out, 1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_tone", bus.tone_out, 0);
    check("rst_async_valid", bus.note_valid, 0);
    check("rst_async_idx", bus.note_idx, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(); cyc();
    check("rst_idle_valid", bus.note_valid, 0);
    cyc();
    check("rst_regrant_valid", bus.note_valid, 1);
    check("rst_regrant_idx", bus.note_idx, 5);
    key_r = 8'h00;

    // Random phase against the reference model.
    rst = 1'b1;
    en_r = 1'b1;
    #3;
    @(posedge clk);
    #1;
    rst     = 1'b0;
    m_mode  = 0;
    m_idx   = 0;
    m_ticks = 0;
    m_gap   = 0;
    m_s1    = 8'h00;
    m_ks    = 8'h00;
    for (int c = 0; c < 20000; c++) begin
      if ($urandom_range(0, 2999) == 0)
        key_r = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      if ($urandom_range(0, 7999) == 0) en_r = ~en_r;
      tick_r = ($urandom_range(0, 3) != 0);
      model_step();
      cyc();
      exp_w = {30'd0, (m_mode == 1), (m_mode == 1) && (((m_ticks / half_tab[m_idx]) % 2) == 1)};
      exp_w = exp_w | (m_idx << 2);
      act_w = {27'd0, bus.note_idx, bus.note_valid, bus.tone_out};
      check($sformatf("rand_c%0d_idx_valid_tone", c), act_w, exp_w);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
